// File: rtl/osbuf_pkg.sv
// osbuf_pkg
// Shared types and width helpers for the oversampled-PFB input overlap buffer.
//   osbuf_state_t : FSM state encoding (FILL / STREAM)
//   ptr_width()   : circular pointer width for a given RAM depth
//   avail_width() : occupancy counter width (holds 0..DEPTH inclusive)
//   idx_width()   : in-frame read index width for a given frame length

package osbuf_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } osbuf_state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so that a completely full RAM (avail == DEPTH) is representable.
    function automatic int avail_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram
// Inferred simple dual-port RAM: one write port, one read port, registered read
// with read enable. The read register only changes on re, so the output holds
// its value between reads (usable directly as a stallable output register).
// Ports:
//   clk          clock
//   rst          synchronous active-high reset, clears the read register only
//   we/waddr/wdata  write port
//   re/raddr     read port request
//   rdata        registered read data, valid the cycle after re

module sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/os_input_buffer.sv
// os_input_buffer
// Input-side overlap buffer for the oversampled PFB. Samples are written
// linearly into a circular RAM; each frame reads M samples newest-first
// starting at base+M-1, then base advances by D so the next frame reuses the
// M-D newest samples of the previous one.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   din, din_valid         input sample stream
//   din_ready              space available (avail < DEPTH)
//   dout, dout_valid       output sample stream, registered
//   dout_ready             downstream accepts dout
//   dout_last              (only with OSBUF_TLAST_EN) marks the oldest
//                          sample x[kD] of each frame
//
// Build option: define OSBUF_TLAST_EN to add the dout_last port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FILL   | waiting for at least M buffered samples beyond base
// STREAM | issuing reads rptr = base+M-1 down to base, one per free slot

module os_input_buffer
    import osbuf_pkg::*;
#(
    parameter int M     = 8,
    parameter int D     = 6,
    parameter int WIDTH = 16,
    parameter int DEPTH = 2 * M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
`ifdef OSBUF_TLAST_EN
    ,
    output logic             dout_last
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = avail_width(DEPTH);
    localparam int IW = idx_width(M);

    osbuf_state_t  state;
    logic [PW-1:0] wptr;
    logic [PW-1:0] base;
    logic [PW-1:0] rptr;
    logic [AW-1:0] avail;
    logic [AW-1:0] avail_nxt;
    logic [IW-1:0] rd_idx;

    logic wr;
    logic issue;
    logic retire;

    // The write slot is always at base+avail with M <= avail < DEPTH while a
    // frame is being read, so it can never alias a read address.
    assign din_ready = !rst && (avail < AW'(DEPTH));
    assign wr        = din_valid && din_ready;
    assign issue     = (state == STREAM) && (!dout_valid || dout_ready);
    assign retire    = issue && (rd_idx == IW'(M - 1));
    assign avail_nxt = avail + AW'(wr) - (retire ? AW'(D) : AW'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            wptr   <= '0;
            base   <= '0;
            rptr   <= '0;
            avail  <= '0;
            rd_idx <= '0;
        end else begin
            avail <= avail_nxt;
            if (wr) begin
                wptr <= wptr + PW'(1);
            end
            case (state)
                FILL: begin
                    if (avail >= AW'(M)) begin
                        rptr   <= base + PW'(M - 1);
                        rd_idx <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (retire) begin
                        base   <= base + PW'(D);
                        rd_idx <= '0;
                        // Chain straight into the next frame when it is already
                        // buffered, so back-to-back frames have no idle slot.
                        if (avail_nxt >= AW'(M)) begin
                            rptr <= base + PW'(D + M - 1);
                        end else begin
                            state <= FILL;
                        end
                    end else if (issue) begin
                        rptr   <= rptr - PW'(1);
                        rd_idx <= rd_idx + IW'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
        end else if (issue) begin
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef OSBUF_TLAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_last <= 1'b0;
        end else if (issue) begin
            dout_last <= retire;
        end
    end
`endif

    // The RAM read register is the output register: it only loads on issue,
    // which keeps dout stable under backpressure.
    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr),
        .waddr (wptr),
        .wdata (din),
        .re    (issue),
        .raddr (rptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_os_input_buffer.sv
module tb_os_input_buffer;

    localparam int M     = 8;
    localparam int D     = 6;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
`ifdef OSBUF_TLAST_EN
    logic             dout_last;
`endif

    os_input_buffer #(
        .M     (M),
        .D     (D),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef OSBUF_TLAST_EN
        ,
        .dout_last  (dout_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard state
    int in_idx;
    int out_idx;
    int in_limit;
    int xbase;
    bit prev_stall;
    logic [WIDTH-1:0] prev_dout;
    logic prev_last;

    // last sampled outputs
    logic             s_din_ready;
    logic             s_dout_valid;
    logic [WIDTH-1:0] s_dout;

    typedef struct {
        bit             dv;
        bit             dr;
        bit             exp_rdy;
        bit             exp_vld;
        logic [WIDTH-1:0] exp_dout;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, account for the
    // handshakes that the following posedge will complete.
    task automatic step(input bit dv, input bit dr);
        int k;
        int n;
        int exp_v;
        @(negedge clk);
        din_valid  = dv && (in_idx < in_limit);
        din        = WIDTH'(xbase + in_idx);
        dout_ready = dr;
        #1;
        s_din_ready  = din_ready;
        s_dout_valid = dout_valid;
        s_dout       = dout;
        if (prev_stall) begin
            chk("hold_valid", 32'(dout_valid), 32'(1));
            chk("hold_dout", 32'(dout), 32'(prev_dout));
`ifdef OSBUF_TLAST_EN
            chk("hold_last", 32'(dout_last), 32'(prev_last));
`endif
        end
        if (dout_valid && dr) begin
            k     = out_idx / M;
            n     = out_idx % M;
            exp_v = xbase + k * D + M - 1 - n;
            chk("dout", 32'(dout), 32'(exp_v & 16'hffff));
`ifdef OSBUF_TLAST_EN
            chk("dout_last", 32'(dout_last), 32'(n == M - 1));
`endif
            out_idx++;
        end
        if (din_valid && din_ready) in_idx++;
        prev_stall = dout_valid && !dr;
        prev_dout  = dout;
`ifdef OSBUF_TLAST_EN
        prev_last  = dout_last;
`else
        prev_last  = 1'b0;
`endif
    endtask

    task automatic do_reset(input int new_base);
        @(negedge clk);
        rst        = 1'b1;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #1;
        chk("rst_din_ready", 32'(din_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_dout_valid", 32'(dout_valid), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("post_rst_din_ready", 32'(din_ready), 32'(1));
`ifdef OSBUF_TLAST_EN
        chk("rst_dout_last", 32'(dout_last), 32'(0));
`endif
        in_idx     = 0;
        out_idx    = 0;
        in_limit   = 1 << 30;
        xbase      = new_base;
        prev_stall = 1'b0;
    endtask

    task automatic run_until(input int target, input bit dv, input bit dr,
                             input int budget, input bit no_bubble);
        int cyc;
        int o;
        cyc = 0;
        while (out_idx < target && cyc < budget) begin
            o = out_idx;
            step(dv, dr);
            if (no_bubble && o > 0 && o < target)
                chk("no_bubble", 32'(s_dout_valid), 32'(1));
            cyc++;
        end
        chk("run_done", 32'(out_idx), 32'(target));
    endtask

    function automatic int frames_out(input int n_in);
        return (n_in >= M) ? ((n_in - M) / D + 1) * M : 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        in_idx     = 0;
        out_idx    = 0;
        in_limit   = 1 << 30;
        xbase      = 0;
        prev_stall = 1'b0;
        prev_dout  = '0;
        prev_last  = 1'b0;

        // cycle-by-cycle expectations for a ramp with dout_ready held high
        for (int c = 0; c < 10; c++) vecs[c] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd7};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd6};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd5};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd4};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd3};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd13};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd12};

        // ramp, back-to-back frames
        do_reset(0);
        for (int c = 0; c < 20; c++) begin
            step(vecs[c].dv, vecs[c].dr);
            chk($sformatf("vec%0d_din_ready", c), 32'(s_din_ready), 32'(vecs[c].exp_rdy));
            chk($sformatf("vec%0d_dout_valid", c), 32'(s_dout_valid), 32'(vecs[c].exp_vld));
            chk($sformatf("vec%0d_dout", c), 32'(s_dout), 32'(vecs[c].exp_dout));
        end
        run_until(3 * M, 1'b1, 1'b1, 100, 1'b1);

        // backpressure: buffer fills to DEPTH, dout holds 7
        do_reset(0);
        for (int c = 0; c < 25; c++) step(1'b1, 1'b0);
        chk("bp_accepted", 32'(in_idx), 32'(DEPTH));
        chk("bp_din_ready", 32'(s_din_ready), 32'(0));
        chk("bp_dout_valid", 32'(s_dout_valid), 32'(1));
        chk("bp_dout", 32'(s_dout), 32'(7));
        run_until(2 * M, 1'b1, 1'b1, 100, 1'b0);

        // wrap: 40 samples, frames 0..5 cross the 15->0 pointer wrap
        do_reset(0);
        in_limit = 40;
        run_until(6 * M, 1'b1, 1'b1, 300, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1);
        chk("wrap_in", 32'(in_idx), 32'(40));
        chk("wrap_out", 32'(out_idx), 32'(6 * M));
        chk("wrap_idle", 32'(s_dout_valid), 32'(0));

        // random handshakes, then drain
        do_reset(0);
        for (int c = 0; c < 1000; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_limit = in_idx;
        for (int c = 0; c < 60; c++) step(1'b0, 1'b1);
        chk("rand_activity", 32'(out_idx > M), 32'(1));
        chk("rand_out_count", 32'(out_idx), 32'(frames_out(in_idx)));

        // reset mid-frame after 3 outputs, then a fresh frame from 100
        do_reset(0);
        run_until(3, 1'b1, 1'b1, 100, 1'b0);
        do_reset(100);
        in_limit = 8;
        run_until(M, 1'b1, 1'b1, 100, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
        chk("rst_frame_out", 32'(out_idx), 32'(M));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
